// File: rtl/bus_arbiter8_pkg.sv
// Shared encodings, sizes and the round-robin pick used by the bus_arbiter8 slice.
// The pick is pure combinational logic; it has no timing or backpressure of its own.
package bus_arbiter8_pkg;

   localparam int N_REQ  = 8;
   localparam int LANE_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Returns {found, index}. Scans ptr+1 .. ptr+8 in 3-bit arithmetic.
   // The loop runs backwards so the nearest requester after ptr is written last and wins.
   function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] ptr);
      logic [2:0] idx;
      logic [3:0] res;
      res = 4'b0000;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = ptr + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_arbiter8_mux.sv
// 8-way 16-bit lane multiplexer, purely combinational (zero latency).
// It holds no state and applies no backpressure.
module Mux8Way16
   import bus_arbiter8_pkg::*;
(
   input  logic [N_REQ*LANE_W-1:0] din,
   input  logic [2:0]              sel,
   output logic [LANE_W-1:0]       out
);

   assign out = din[{sel, 4'b0000} +: LANE_W];

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin owner of a 16-bit bus that holds each grant until the burst's last word; 1-cycle grant latency.
// A stalled sink (out_ready low) or an owner with no word freezes the grant; transfers need out_valid & out_ready.
module bus_arbiter8
   import bus_arbiter8_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   req,
   input  logic [7:0]   last,
   input  logic [127:0] din,
   input  logic         out_ready,
   output logic [15:0]  out,
   output logic         out_valid,
   output logic         out_last,
   output logic [7:0]   gnt,
   output logic [2:0]   sel,
   output logic         busy
);

   state_t     state;
   logic [2:0] ptr;
   logic [3:0] idle_pick;
   logic [3:0] rel_pick;
   logic       xfer;

   Mux8Way16 u_mux (
      .din (din),
      .sel (sel),
      .out (out)
   );

   assign out_valid = busy & req[sel];
   assign out_last  = out_valid & last[sel];
   assign xfer      = out_valid & out_ready;

   // On release the owner is masked so it cannot win back its own slot on the same edge.
   assign idle_pick = rr_pick(req, ptr);
   assign rel_pick  = rr_pick(req & ~(8'b1 << sel), sel);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sel   <= 3'd0;
         ptr   <= 3'd7;
         gnt   <= 8'h00;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (idle_pick[3]) begin
                  state <= OWN;
                  sel   <= idle_pick[2:0];
                  gnt   <= 8'b1 << idle_pick[2:0];
                  busy  <= 1'b1;
               end
            end
            OWN: begin
               if (xfer && last[sel]) begin
                  ptr <= sel;
                  if (rel_pick[3]) begin
                     sel <= rel_pick[2:0];
                     gnt <= 8'b1 << rel_pick[2:0];
                  end else begin
                     state <= IDLE;
                     gnt   <= 8'h00;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 8'h00;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
